count_sched: RTL and testbench

- Round-robin scheduler that shares one tick-paced up-counter engine among N_REQ requesters (board buttons or internal agents).
- Each granted requester gets one run: the count goes 0 up to that requester's terminal value, then a one-cycle done pulse.
- Sits between debounced request sources and the LED display / downstream logic.
- Single clock domain: pacing uses a clock-enable tick, never a derived clock.

---
 rtl/count_sched_pkg.sv | 39 +++
 rtl/count_sched_tick_gen.sv | 28 ++
 rtl/count_sched.sv | 131 +++++++++++++
 tb/tb_count_sched.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and helpers for the round-robin count scheduler.
// The pick function works on a fixed-width view so one definition serves every N_REQ.
package count_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  // Owner index width, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot of the first set request at or above ptr, wrapping within the low n bits.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input int unsigned       ptr,
                                                input int unsigned       n);
    logic [MaxReq-1:0]  oh;
    logic               found;
    logic [MaxIdxW-1:0] idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      idx = MaxIdxW'((ptr + i) % n);
      if ((i < n) && !found && req[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/count_sched_tick_gen.sv
// Free-running clock-enable divider: tick is high for one clk every TICK_DIV cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     DivW    = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? '0 : div_q + DivW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler sharing one tick-paced up-counter among N_REQ requesters.
// Each grant runs the count from 0 to the owner's latched limit, then pulses done.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TICK_DIV = 1500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] limit,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [CNT_W-1:0]       count,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       abort
);

  localparam int unsigned IdxW = idx_width(N_REQ);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] abort_q, abort_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  logic              tick;
  logic [MaxReq-1:0] req_ext;
  logic [MaxReq-1:0] pick_oh;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   owner_inc;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  always_comb begin
    req_ext             = '0;
    req_ext[N_REQ-1:0]  = req;
    pick_oh             = rr_pick(req_ext, 32'(ptr_q), N_REQ);
    pick_idx            = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (pick_oh[i]) pick_idx = IdxW'(i);
    end
    owner_inc = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + IdxW'(1);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    count_d = count_q;
    lim_d   = lim_q;
    abort_d = '0;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d = pick_idx;
          grant_d = pick_oh[N_REQ-1:0];
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
          if (owner_q == IdxW'(i)) lim_d = limit[i*CNT_W +: CNT_W];
        end
        state_d = StRun;
      end
      StRun: begin
        // Losing the request outranks a tick landing in the same cycle.
        if (!req[owner_q]) begin
          abort_d = grant_q;
          grant_d = '0;
          count_d = '0;
          ptr_d   = owner_inc;
          state_d = StIdle;
        end else if (tick) begin
          if (count_q == lim_q) begin
            state_d = StDone;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      StDone: begin
        grant_d = '0;
        count_d = '0;
        ptr_d   = owner_inc;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      abort_q <= '0;
      count_q <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
      count_q <= count_d;
      lim_q   <= lim_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == StLoad) || (state_q == StRun);
  assign count = count_q;
  assign done  = (state_q == StDone) ? grant_q : '0;
  assign abort = abort_q;

endmodule

// File: tb/tb_count_sched.sv
// Randomised bench for count_sched: a behavioural scheduler model predicts every cycle
// and queues expected done/abort events; a negedge monitor pops and compares them.
module tb_count_sched;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TD = 4;

  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MRun  = 2;
  localparam int MDone = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] limit = '0;
  logic [N-1:0]   grant, done, abort;
  logic           busy;
  logic [W-1:0]   count;

  count_sched #(
    .N_REQ   (N),
    .CNT_W   (W),
    .TICK_DIV(TD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .limit(limit),
    .grant(grant),
    .busy (busy),
    .count(count),
    .done (done),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_abort;
    int owner;
    int cnt;
  } ev_t;

  ev_t exp_q[$];

  // Reference scheduler state, expressed as plain integers.
  int m_state = MIdle;
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_lim   = 0;
  int m_div   = 0;
  int m_abort_owner = -1;

  int n_done[N];
  int n_abort[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_lim   = 0;
    m_div   = 0;
    m_abort_owner = -1;
    exp_q.delete();
  endtask

  task automatic end_run();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_cnt   = 0;
    m_state = MIdle;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit tick;
    bit found;
    int c;
    tick  = (m_div == TD - 1);
    m_div = (m_div + 1) % TD;
    m_abort_owner = -1;
    case (m_state)
      MIdle: begin
        if (req != 0) begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && req[c]) begin
              m_owner = c;
              found   = 1;
            end
          end
          m_state = MLoad;
        end
      end
      MLoad: begin
        m_lim   = int'(limit >> (m_owner * W)) & ((1 << W) - 1);
        m_cnt   = 0;
        m_state = MRun;
      end
      MRun: begin
        if (!req[m_owner]) begin
          exp_q.push_back('{1'b1, m_owner, 0});
          m_abort_owner = m_owner;
          end_run();
        end else if (tick) begin
          if (m_cnt == m_lim) begin
            exp_q.push_back('{1'b0, m_owner, m_cnt});
            m_state = MDone;
          end else begin
            m_cnt++;
          end
        end
      end
      default: end_run();
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] eg, ed, ea, pd, pa;
    logic         eb;
    ev_t          ev;
    eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    eb = (m_state == MLoad) || (m_state == MRun);
    ed = (m_state == MDone) ? eg : '0;
    ea = (m_abort_owner >= 0) ? N'(1 << m_abort_owner) : '0;
    check("outputs", 32'({grant, busy, count, done, abort}), 32'({eg, eb, W'(m_cnt), ed, ea}));
    check("invariant", 32'({$onehot0(grant), |(done & abort)}), 32'({1'b1, 1'b0}));
    for (int i = 0; i < N; i++) begin
      if (done[i]) n_done[i]++;
      if (abort[i]) n_abort[i]++;
    end
    if ((done | abort) != 0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({done, abort}), 32'(0));
      end else begin
        ev = exp_q.pop_front();
        pd = ev.is_abort ? '0 : N'(1 << ev.owner);
        pa = ev.is_abort ? N'(1 << ev.owner) : '0;
        check("event", 32'({done, abort, count}), 32'({pd, pa, W'(ev.cnt)}));
      end
    end
  end

  task automatic wait_run_cnt(input int cnt, input string name);
    int b;
    b = 0;
    while (!(m_state == MRun && m_cnt == cnt) && b < 300) begin
      cycle();
      b++;
    end
    if (b >= 300) check({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  initial begin
    int na, nd, b;
    for (int i = 0; i < N; i++) begin
      n_done[i]  = 0;
      n_abort[i] = 0;
    end
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;

    // Idle with no requests.
    repeat (100) cycle();

    // Single requester, limit 3, held through completion and re-grant.
    limit = 16'h0003;
    req   = 4'b0001;
    repeat (60) cycle();
    check("req0_done_seen", 32'(n_done[0] >= 2), 32'(1));
    req = '0;
    repeat (10) cycle();

    // Fairness: everyone requesting, zero limits.
    limit = '0;
    req   = 4'b1111;
    repeat (80) cycle();
    check("fair_all_done", 32'({n_done[3] > 0, n_done[2] > 0, n_done[1] > 1}), 32'(3'b111));
    req = '0;
    repeat (10) cycle();

    // Abort at count 5, then pointer must wrap to requester 0.
    limit = 16'h0900;
    req   = 4'b0100;
    na    = n_abort[2];
    wait_run_cnt(5, "abort_wait");
    req = '0;
    cycle();
    req = 4'b0101;
    cycle();
    check("ptr_wrap_grant", 32'(grant), 32'(4'b0001));
    check("abort_seen", 32'(n_abort[2] - na), 32'(1));
    req = '0;
    repeat (10) cycle();

    // Drop the request in the very cycle the terminal tick lands.
    limit = 16'h0020;
    req   = 4'b0010;
    b     = 0;
    while (!(m_state == MRun && m_cnt == m_lim && m_div == TD - 1) && b < 300) begin
      cycle();
      b++;
    end
    if (b >= 300) check("collide_timeout", 32'(0), 32'(1));
    na  = n_abort[1];
    nd  = n_done[1];
    req = '0;
    cycle();
    cycle();
    check("collide_abort", 32'(n_abort[1] - na), 32'(1));
    check("collide_no_done", 32'(n_done[1] - nd), 32'(0));
    repeat (5) cycle();

    // Full-scale limit: count must reach 15 without wrapping, then reset mid-run.
    limit = 16'hF000;
    req   = 4'b1000;
    b     = 0;
    while (m_state != MDone && b < 300) begin
      cycle();
      b++;
    end
    if (b >= 300) check("max_timeout", 32'(0), 32'(1));
    check("max_count", 32'(count), 32'(15));
    wait_run_cnt(7, "rst_wait");
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_reset", 32'({grant, busy, count, done, abort}), 32'(0));
    cycle();
    cycle();
    rst = 1'b0;
    repeat (20) cycle();

    // Random requests and limits.
    for (int t = 0; t < 3000; t++) begin
      if (t % 50 == 0) begin
        for (int i = 0; i < N; i++) begin
          limit[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15))
                                                        : W'($urandom_range(0, 3));
        end
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) req[i] = ~req[i];
      end
      cycle();
    end

    req = '0;
    repeat (10) cycle();
    check("queue_drain", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
